// File: rtl/d_horner_eval_gf12.sv
// Horner-rule polynomial evaluator over GF(2^12), P(x) = x^12 + x^7 + x^4 + x^3 + 1.
// Optional macro D_HORNER_MUL_REG_EN registers the field product (two-phase accumulate).
module d_horner_eval_gf12 #(
    parameter int MAX_DEGREE = 14,
    parameter int DW         = 4
) (
    input  logic          i_clk,
    input  logic          i_nRESET,
    input  logic          i_start,
    input  logic [11:0]   i_point,
    input  logic [DW-1:0] i_degree,
    input  logic          i_coef_valid,
    input  logic [11:0]   i_coef,
    output logic          o_coef_ready,
    output logic          o_busy,
    output logic          o_result_valid,
    input  logic          i_result_ready,
    output logic [11:0]   o_result,
    output logic          o_is_root
);

    // The counter is one bit wider than the degree field so d+1 never wraps.
    localparam int CW = DW + 1;
    localparam logic [CW-1:0] MAX_DEG_C = CW'(MAX_DEGREE);
    localparam logic [11:0]   POLY_LOW  = 12'h099;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Combinational GF(2^12) product: shift-and-add with reduction by x^12 = POLY_LOW.
    function automatic logic [11:0] ffm_gf12(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] p;
        logic [11:0] sh;
        p  = 12'h000;
        sh = a;
        for (int i = 0; i < 12; i++) begin
            if (b[i]) begin
                p = p ^ sh;
            end else begin
                p = p;
            end
            if (sh[11]) begin
                sh = {sh[10:0], 1'b0} ^ POLY_LOW;
            end else begin
                sh = {sh[10:0], 1'b0};
            end
        end
        return p;
    endfunction

    state_t        state_q, state_d;
    logic [11:0]   point_q, point_d;
    logic [11:0]   acc_q, acc_d;
    logic [11:0]   result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          coef_ready_q, coef_ready_d;
    logic          result_valid_q, result_valid_d;
    logic          is_root_q, is_root_d;

    logic [11:0]   ffm_s;
    logic [11:0]   acc_next_s;
    logic [CW-1:0] deg_s;
    logic          accept_s;

    assign ffm_s    = ffm_gf12(acc_q, point_q);
    assign accept_s = (state_q == ST_ACCUM) & i_coef_valid & coef_ready_q;
    assign deg_s    = ({1'b0, i_degree} > MAX_DEG_C) ? MAX_DEG_C : {1'b0, i_degree};

`ifdef D_HORNER_MUL_REG_EN
    logic          phase_q, phase_d;
    logic [11:0]   prod_q, prod_d;

    assign acc_next_s = prod_q ^ i_coef;

    // Phase 0 captures the product, phase 1 waits for a coefficient to fold in.
    always_comb begin
        phase_d = phase_q;
        prod_d  = prod_q;
        if (state_q == ST_ACCUM) begin
            if (!phase_q) begin
                prod_d  = ffm_s;
                phase_d = 1'b1;
            end else if (accept_s) begin
                phase_d = 1'b0;
            end else begin
                phase_d = 1'b1;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Product pipeline registers.
    always_ff @(posedge i_clk) begin
        if (!i_nRESET) begin
            phase_q <= 1'b0;
            prod_q  <= 12'h000;
        end else begin
            phase_q <= phase_d;
            prod_q  <= prod_d;
        end
    end
`else
    assign acc_next_s = ffm_s ^ i_coef;
`endif

    // State register and datapath flops.
    always_ff @(posedge i_clk) begin
        if (!i_nRESET) begin
            state_q        <= ST_IDLE;
            point_q        <= 12'h000;
            acc_q          <= 12'h000;
            result_q       <= 12'h000;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            coef_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
            is_root_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            point_q        <= point_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            coef_ready_q   <= coef_ready_d;
            result_valid_q <= result_valid_d;
            is_root_q      <= is_root_d;
        end
    end

    // Next-state and accumulate logic.
    always_comb begin
        state_d  = state_q;
        point_d  = point_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    point_d = i_point;
                    acc_d   = 12'h000;
                    cnt_d   = deg_s + CW'(1);
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = acc_next_s;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (i_result_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_DONE);
        is_root_d      = (state_d == ST_DONE) && (result_d == 12'h000);
`ifdef D_HORNER_MUL_REG_EN
        coef_ready_d   = (state_d == ST_ACCUM) && phase_d;
`else
        coef_ready_d   = (state_d == ST_ACCUM);
`endif
    end

    assign o_coef_ready   = coef_ready_q;
    assign o_busy         = busy_q;
    assign o_result_valid = result_valid_q;
    assign o_result       = result_q;
    assign o_is_root      = is_root_q;

endmodule

// File: tb/tb_d_horner_eval_gf12.sv
// Directed, table-driven bench for d_horner_eval_gf12 (both builds of D_HORNER_MUL_REG_EN).
module tb_d_horner_eval_gf12;

    logic        i_clk = 1'b0;
    logic        i_nRESET;
    logic        i_start;
    logic [11:0] i_point;
    logic [3:0]  i_degree;
    logic        i_coef_valid;
    logic [11:0] i_coef;
    logic        o_coef_ready;
    logic        o_busy;
    logic        o_result_valid;
    logic        i_result_ready;
    logic [11:0] o_result;
    logic        o_is_root;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    d_horner_eval_gf12 #(.MAX_DEGREE(14), .DW(4)) dut (
        .i_clk          (i_clk),
        .i_nRESET       (i_nRESET),
        .i_start        (i_start),
        .i_point        (i_point),
        .i_degree       (i_degree),
        .i_coef_valid   (i_coef_valid),
        .i_coef         (i_coef),
        .o_coef_ready   (o_coef_ready),
        .o_busy         (o_busy),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_result       (o_result),
        .o_is_root      (o_is_root)
    );

    typedef struct {
        logic [11:0]       point;
        logic [3:0]        degree;
        int                n;
        logic [15:0][11:0] c;
        logic [11:0]       exp_res;
        logic              exp_root;
    } vec_t;

    vec_t tbl[9];

    task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

`ifdef D_HORNER_MUL_REG_EN
    logic prev_rdy = 1'b0;
    always @(negedge i_clk) begin
        if (o_coef_ready === 1'b1) chk1("rdy_not_back_to_back", prev_rdy, 1'b0);
        prev_rdy <= o_coef_ready;
    end
`endif

    task automatic run_eval(input logic [11:0] pt, input logic [3:0] dg, input int n,
                            input logic [15:0][11:0] c, input bit gaps, input int hold,
                            input bit start_with_ready, output logic [11:0] res, output logic root);
        int idx;
        int budget;
        @(negedge i_clk);
        i_point  = pt;
        i_degree = dg;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        chk1("busy_after_start", o_busy, 1'b1);
        idx = 0;
        budget = 0;
        while (idx < n && budget < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_coef_valid = 1'b0;
                i_coef       = 12'($urandom);
                i_start      = 1'($urandom_range(0, 1));
            end else begin
                i_coef_valid = 1'b1;
                i_coef       = c[idx];
                i_start      = 1'b0;
                if (o_coef_ready === 1'b1) idx++;
            end
            @(negedge i_clk);
            budget++;
        end
        i_coef_valid = 1'b0;
        i_start      = 1'b0;
        if (budget >= 200) begin
            checks++;
            errors++;
            $display("FAIL coef_timeout accepted=%0d required=%0d", idx, n);
        end
        chk1("valid_after_last", o_result_valid, 1'b1);
        res  = o_result;
        root = o_is_root;
        for (int h = 0; h < hold; h++) begin
            i_start      = h[0];
            i_coef_valid = 1'b1;
            i_coef       = 12'hFFF;
            @(negedge i_clk);
            chk12("result_held", o_result, res);
            chk1("valid_held", o_result_valid, 1'b1);
        end
        i_coef_valid   = 1'b0;
        i_result_ready = 1'b1;
        i_start        = start_with_ready;
        @(negedge i_clk);
        i_result_ready = 1'b0;
        i_start        = 1'b0;
        chk1("valid_drop", o_result_valid, 1'b0);
        chk1("busy_drop", o_busy, 1'b0);
        @(negedge i_clk);
        chk1("idle_stays", o_busy, 1'b0);
    endtask

    initial begin
        logic [11:0]       r;
        logic              rt;
        logic [15:0][11:0] cc;
        int                acc_cnt;
        int                b;

        tbl[0] = '{point: 12'h001, degree: 4'd1,  n: 2,  c: '0, exp_res: 12'h000, exp_root: 1'b1};
        tbl[0].c[0] = 12'h001; tbl[0].c[1] = 12'h001;
        tbl[1] = '{point: 12'h002, degree: 4'd2,  n: 3,  c: '0, exp_res: 12'h004, exp_root: 1'b0};
        tbl[1].c[0] = 12'h001;
        tbl[2] = '{point: 12'h002, degree: 4'd12, n: 13, c: '0, exp_res: 12'h099, exp_root: 1'b0};
        tbl[2].c[0] = 12'h001;
        tbl[3] = '{point: 12'h5A5, degree: 4'd0,  n: 1,  c: '0, exp_res: 12'hABC, exp_root: 1'b0};
        tbl[3].c[0] = 12'hABC;
        tbl[4] = '{point: 12'h000, degree: 4'd3,  n: 4,  c: '0, exp_res: 12'h123, exp_root: 1'b0};
        tbl[4].c[0] = 12'h005; tbl[4].c[1] = 12'h006; tbl[4].c[2] = 12'h007; tbl[4].c[3] = 12'h123;
        // Degree 15 clamps to 14: x^14 reduces to 0x264.
        tbl[5] = '{point: 12'h002, degree: 4'd15, n: 15, c: '0, exp_res: 12'h264, exp_root: 1'b0};
        tbl[5].c[0] = 12'h001;
        tbl[6] = '{point: 12'h003, degree: 4'd2,  n: 3,  c: '0, exp_res: 12'h005, exp_root: 1'b0};
        tbl[6].c[0] = 12'h001;
        tbl[7] = '{point: 12'h800, degree: 4'd1,  n: 2,  c: '0, exp_res: 12'h800, exp_root: 1'b0};
        tbl[7].c[0] = 12'h001;
        tbl[8] = '{point: 12'h002, degree: 4'd1,  n: 2,  c: '0, exp_res: 12'h098, exp_root: 1'b0};
        tbl[8].c[0] = 12'h800; tbl[8].c[1] = 12'h001;

        i_nRESET = 1'b0; i_start = 1'b0; i_point = 12'h000; i_degree = 4'd0;
        i_coef_valid = 1'b0; i_coef = 12'h000; i_result_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_coef_ready", o_coef_ready, 1'b0);
        chk1("rst_valid", o_result_valid, 1'b0);
        chk1("rst_is_root", o_is_root, 1'b0);
        chk12("rst_result", o_result, 12'h000);
        i_nRESET = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_eval(tbl[i].point, tbl[i].degree, tbl[i].n, tbl[i].c, 1'b0, 0, 1'b0, r, rt);
            chk12($sformatf("vec%0d_result", i), r, tbl[i].exp_res);
            chk1($sformatf("vec%0d_is_root", i), rt, tbl[i].exp_root);
        end

        // Valid gaps, stray starts, result held for 5 cycles, start coincident with ready.
        cc = '0; cc[0] = 12'h001;
        run_eval(12'h002, 4'd12, 13, cc, 1'b1, 5, 1'b1, r, rt);
        chk12("gaps_result", r, 12'h099);
        chk1("gaps_is_root", rt, 1'b0);

        // Reset after 2 of 4 coefficients.
        @(negedge i_clk);
        i_point = 12'h002; i_degree = 4'd3; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        acc_cnt = 0;
        b = 0;
        while (acc_cnt < 2 && b < 20) begin
            i_coef_valid = 1'b1;
            i_coef       = 12'h007;
            if (o_coef_ready === 1'b1) acc_cnt++;
            @(negedge i_clk);
            b++;
        end
        i_coef_valid = 1'b0;
        i_nRESET     = 1'b0;
        @(negedge i_clk);
        chk1("midrst_busy", o_busy, 1'b0);
        chk1("midrst_coef_ready", o_coef_ready, 1'b0);
        chk1("midrst_valid", o_result_valid, 1'b0);
        chk1("midrst_is_root", o_is_root, 1'b0);
        chk12("midrst_result", o_result, 12'h000);
        i_nRESET = 1'b1;
        cc = '0; cc[0] = 12'h001; cc[1] = 12'h001; cc[2] = 12'h001; cc[3] = 12'h001;
        run_eval(12'h002, 4'd3, 4, cc, 1'b0, 0, 1'b0, r, rt);
        chk12("after_rst_result", r, 12'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
